simd_downscale_ctrl: RTL and testbench
======================================

// Module: simd_downscale_ctrl
// PURPOSE
//  Frame sequencer for the 4-lane bilinear SIMD datapath (simd_registers + bilinear_interp_simd).
//  - Walks destination pixels in groups of LANES, one output row at a time.
//  - Computes Q8.8 source coordinates and fetches a 5x2 source window from frame memory.
//  - Loads the window into the register stage, pulses the core, then streams each result vector out.
// PARAMETERS
//  LANES     4    pixels per SIMD group, matching the core width
//  WIN       5    source pixels per window row
//  DIM_W     12   width of all image dimension/coordinate fields
//  WAIT_MAX  64   cycles allowed for i_simd_valid before error abort
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          synchronous active-low reset
//  i_start        in   1          start-frame pulse; ignored while o_busy
//  i_abort        in   1          terminate the frame; no o_done pulse
//  i_src_w/i_src_h in  DIM_W      source size, each >= WIN/2
//  i_dst_w/i_dst_h in  DIM_W      destination size, each >= 1
//  i_step_x/i_step_y in 16        Q8.8 source step per destination pixel
//  o_fetch_req    out  1          window fetch request
//  o_fetch_x      out  DIM_W      window start column
//  o_fetch_y0/y1  out  DIM_W      top/bottom source rows
//  i_fetch_ack    in   1          one-cycle ack; row data valid this cycle
//  i_fetch_row0/1 in   WIN*8      5x8-bit window rows
//  o_row0/o_row1  out  WIN*8      captured window rows, to simd_registers
//  o_load_en      out  1          register-stage load pulse
//  o_simd_start   out  1          core start pulse
//  o_wx/o_wy      out  16         Q8.8 weights {8'h00,frac}
//  i_simd_valid   in   1          core result valid
//  i_pixel_vec    in   LANES*8    core result vector
//  o_pix_valid    out  1          output vector valid
//  o_pix_data     out  LANES*8    held result vector
//  o_pix_mask     out  LANES      lane-valid mask for the group
//  o_pix_x/o_pix_y out DIM_W      destination coordinate of lane 0
//  i_pix_ready    in   1          downstream accept
//  o_busy/o_done/o_err out 1      status; o_done/o_err are 1-cycle pulses
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; accumulators and counters 0.
//  - FSM: IDLE->FETCH->LOAD->START->WAIT->OUT->(FETCH | DONE)->IDLE.
//    - IDLE: on i_start, latch all i_* config and set o_busy=1.
//    - FETCH: hold o_fetch_req and the fetch address stable until i_fetch_ack; capture the row data on ack.
//    - LOAD: assert o_load_en for exactly 1 cycle.
//    - START: assert o_simd_start for exactly 1 cycle; o_wx/o_wy hold stable from START until OUT exits.
//    - WAIT: wait for i_simd_valid; it is counted as valid if asserted in the START cycle.
//      - After WAIT_MAX cycles without it: pulse o_err, go IDLE.
//    - OUT: capture i_pixel_vec; hold o_pix_valid and the data until i_pix_ready (valid/ready, no combinational ready->valid path).
//  - Coordinates (unsigned Q(DIM_W).8 accumulators): sx += LANES*step_x per group; sy += step_y per row; sx resets to 0 at row start.
//    - fetch_x = min(int(sx), src_w-WIN); y0 = min(int(sy), src_h-1); y1 = min(y0+1, src_h-1).
//    - wx = frac(sx), wy = frac(sy).
//  - Last group of a row with dst_w%LANES != 0: o_pix_mask = (1<<(dst_w%LANES))-1; otherwise all ones.
//  - After the last group of the last row: o_done for 1 cycle, o_busy=0, back to IDLE.
//  - Per-group latency (zero-wait fetch, core, output): 2 cycles FETCH/LOAD + 1 START + core latency + 1 OUT.
//  - i_abort in any state: IDLE on the next edge, all pulses cleared.
//    - i_abort takes priority over i_start and i_fetch_ack in the same cycle.
//  - rst_n low mid-frame behaves as abort and also clears the status outputs.
// STRUCTURE
//  - simd_pkg holds:
//    - typedef ctrl_state_e;
//    - typedef q8_8_t (logic [15:0]);
//    - constants LANES=4, WIN=5, FRAC_W=8.
//  - Sub-module simd_coord_gen holds the sx/sy accumulators, clamping and end-of-row/frame flags (advance pulse in; coords, weights, mask, last out).
// TESTING
//  - 8x2->4x1, step 0x0200, zero-wait fetch, row data 10..50 -> one vector, wx=wy=0, mask 4'hF, o_done 1 cycle after the handshake.
//  - src 10x4, dst 6x2, step_x 0x0180 -> 4 groups in total; the second group of each row has mask 4'b0011; fetch_x clamped to 5.
//  - Hold i_pix_ready=0 for 7 cycles -> o_pix_valid/data/x/y held stable; no new fetch issued.
//  - Never assert i_simd_valid -> o_err after WAIT_MAX cycles, o_busy=0, o_done never pulses.
//  - i_abort during FETCH together with i_fetch_ack -> IDLE on the next cycle, no o_load_en; a following i_start runs a clean frame.
//  - rst_n low in the WAIT state -> all outputs 0 on the next edge; a new frame then completes normally.

Source files
------------

// File: rtl/simd_downscale_ctrl_pkg.sv
// simd_pkg: shared types and constants for the 4-lane bilinear downscale sequencer.
package simd_pkg;
    localparam int LANES    = 4;
    localparam int WIN      = 5;
    localparam int FRAC_W   = 8;
    localparam int DIM_W    = 12;
    localparam int WAIT_MAX = 64;

    typedef logic [15:0] q8_8_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_OUT, S_DONE} ctrl_state_e;

    typedef struct packed {
        logic [DIM_W-1:0] src_w;
        logic [DIM_W-1:0] src_h;
        logic [DIM_W-1:0] dst_w;
        logic [DIM_W-1:0] dst_h;
        q8_8_t            step_x;
        q8_8_t            step_y;
    } cfg_t;
endpackage

// File: rtl/simd_downscale_ctrl_if.sv
// simd_downscale_ctrl_if: config, window-fetch, core and pixel-stream signals of the sequencer.
interface simd_downscale_ctrl_if;
    import simd_pkg::*;
    logic                   i_start, i_abort;
    logic [DIM_W-1:0]       i_src_w, i_src_h, i_dst_w, i_dst_h;
    q8_8_t                  i_step_x, i_step_y;
    logic                   o_fetch_req, i_fetch_ack;
    logic [DIM_W-1:0]       o_fetch_x, o_fetch_y0, o_fetch_y1;
    logic [WIN*8-1:0]       i_fetch_row0, i_fetch_row1, o_row0, o_row1;
    logic                   o_load_en, o_simd_start, i_simd_valid;
    q8_8_t                  o_wx, o_wy;
    logic [LANES*8-1:0]     i_pixel_vec, o_pix_data;
    logic                   o_pix_valid, i_pix_ready;
    logic [LANES-1:0]       o_pix_mask;
    logic [DIM_W-1:0]       o_pix_x, o_pix_y;
    logic                   o_busy, o_done, o_err;

    modport master (
        input  i_start, i_abort, i_src_w, i_src_h, i_dst_w, i_dst_h, i_step_x, i_step_y,
        input  i_fetch_ack, i_fetch_row0, i_fetch_row1, i_simd_valid, i_pixel_vec, i_pix_ready,
        output o_fetch_req, o_fetch_x, o_fetch_y0, o_fetch_y1, o_row0, o_row1,
        output o_load_en, o_simd_start, o_wx, o_wy,
        output o_pix_valid, o_pix_data, o_pix_mask, o_pix_x, o_pix_y, o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_abort, i_src_w, i_src_h, i_dst_w, i_dst_h, i_step_x, i_step_y,
        output i_fetch_ack, i_fetch_row0, i_fetch_row1, i_simd_valid, i_pixel_vec, i_pix_ready,
        input  o_fetch_req, o_fetch_x, o_fetch_y0, o_fetch_y1, o_row0, o_row1,
        input  o_load_en, o_simd_start, o_wx, o_wy,
        input  o_pix_valid, o_pix_data, o_pix_mask, o_pix_x, o_pix_y, o_busy, o_done, o_err
    );
endinterface

// File: rtl/simd_downscale_ctrl_coord_gen.sv
// simd_coord_gen: Q(DIM_W).8 source accumulators, clamped window address, weights,
// lane mask and end-of-frame flag for the current destination group.
module simd_coord_gen
    import simd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_i,
    input  logic             adv_i,
    input  cfg_t             cfg_i,
    output logic [DIM_W-1:0] fetch_x_o,
    output logic [DIM_W-1:0] fetch_y0_o,
    output logic [DIM_W-1:0] fetch_y1_o,
    output logic [DIM_W-1:0] gx_o,
    output logic [DIM_W-1:0] gy_o,
    output q8_8_t            wx_o,
    output q8_8_t            wy_o,
    output logic [LANES-1:0] mask_o,
    output logic             frame_last_o
);
    localparam int AW = DIM_W + FRAC_W;
    localparam int LB = $clog2(LANES);

    logic [AW-1:0]    sx_q, sx_d, sy_q, sy_d;
    logic [DIM_W-1:0] gx_q, gx_d, gy_q, gy_d, ix, iy, x_max, y_max, y0;
    logic [DIM_W:0]   gx_next;
    logic [LB-1:0]    rem;
    logic             row_last;

    assign gx_next      = {1'b0, gx_q} + (DIM_W+1)'(LANES);
    assign row_last     = gx_next >= {1'b0, cfg_i.dst_w};
    assign frame_last_o = row_last && gy_q == cfg_i.dst_h - DIM_W'(1);
    assign rem          = cfg_i.dst_w[LB-1:0];

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        gx_d = gx_q;
        gy_d = gy_q;
        if (init_i) begin
            sx_d = '0;
            sy_d = '0;
            gx_d = '0;
            gy_d = '0;
        end else if (adv_i) begin
            sx_d = row_last ? '0 : sx_q + AW'(cfg_i.step_x) * AW'(LANES);
            gx_d = row_last ? '0 : gx_next[DIM_W-1:0];
            sy_d = row_last ? sy_q + AW'(cfg_i.step_y) : sy_q;
            gy_d = row_last ? gy_q + DIM_W'(1) : gy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sx_q <= '0;
            sy_q <= '0;
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    // a source narrower than the window pins the window at column 0
    assign ix         = sx_q[AW-1:FRAC_W];
    assign iy         = sy_q[AW-1:FRAC_W];
    assign x_max      = cfg_i.src_w > DIM_W'(WIN) ? cfg_i.src_w - DIM_W'(WIN) : '0;
    assign y_max      = cfg_i.src_h - DIM_W'(1);
    assign fetch_x_o  = ix > x_max ? x_max : ix;
    assign y0         = iy > y_max ? y_max : iy;
    assign fetch_y0_o = y0;
    assign fetch_y1_o = y0 >= y_max ? y_max : y0 + DIM_W'(1);
    assign wx_o       = {8'h00, sx_q[FRAC_W-1:0]};
    assign wy_o       = {8'h00, sy_q[FRAC_W-1:0]};
    assign mask_o     = (row_last && rem != '0) ? ~({LANES{1'b1}} << rem) : '1;
    assign gx_o       = gx_q;
    assign gy_o       = gy_q;
endmodule

// File: rtl/simd_downscale_ctrl.sv
// simd_downscale_ctrl: frame sequencer that fetches a 5x2 window per 4-pixel group,
// loads and starts the SIMD core, then streams each result vector out.
module simd_downscale_ctrl
    import simd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    simd_downscale_ctrl_if.master bus
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    ctrl_state_e        state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [WIN*8-1:0]   row0_q, row0_d, row1_q, row1_d;
    logic [LANES*8-1:0] pix_q, pix_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic               err_q, err_d, init, adv, frame_last, fetch_req, pix_valid;
    logic [DIM_W-1:0]   fetch_x, fetch_y0, fetch_y1, gx, gy;
    logic [LANES-1:0]   mask;

    simd_coord_gen u_coord (
        .clk(clk), .rst_n(rst_n), .init_i(init), .adv_i(adv), .cfg_i(cfg_q),
        .fetch_x_o(fetch_x), .fetch_y0_o(fetch_y0), .fetch_y1_o(fetch_y1),
        .gx_o(gx), .gy_o(gy), .wx_o(bus.o_wx), .wy_o(bus.o_wy),
        .mask_o(mask), .frame_last_o(frame_last)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        row0_d  = row0_q;
        row1_d  = row1_q;
        pix_d   = pix_q;
        wait_d  = '0;
        err_d   = 1'b0;
        init    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.i_start) begin
                state_d = S_FETCH;
                init    = 1'b1;
                cfg_d   = '{src_w: bus.i_src_w, src_h: bus.i_src_h, dst_w: bus.i_dst_w,
                            dst_h: bus.i_dst_h, step_x: bus.i_step_x, step_y: bus.i_step_y};
            end
            S_FETCH: if (bus.i_fetch_ack) begin
                state_d = S_LOAD;
                row0_d  = bus.i_fetch_row0;
                row1_d  = bus.i_fetch_row1;
            end
            S_LOAD: state_d = S_START;
            // a result already valid during START skips WAIT entirely
            S_START, S_WAIT: if (bus.i_simd_valid) begin
                state_d = S_OUT;
                pix_d   = bus.i_pixel_vec;
            end else if (state_q == S_WAIT && wait_q == CW'(WAIT_MAX - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                state_d = S_WAIT;
                wait_d  = state_q == S_WAIT ? wait_q + CW'(1) : '0;
            end
            S_OUT: if (bus.i_pix_ready) begin
                adv     = 1'b1;
                state_d = frame_last ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.i_abort) begin
            state_d = S_IDLE;
            cfg_d   = cfg_q;
            err_d   = 1'b0;
            init    = 1'b0;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            row0_q  <= '0;
            row1_q  <= '0;
            pix_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            pix_q   <= pix_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign fetch_req        = state_q == S_FETCH;
    assign pix_valid        = state_q == S_OUT;
    assign bus.o_fetch_req  = fetch_req;
    assign bus.o_fetch_x    = fetch_req ? fetch_x : '0;
    assign bus.o_fetch_y0   = fetch_req ? fetch_y0 : '0;
    assign bus.o_fetch_y1   = fetch_req ? fetch_y1 : '0;
    assign bus.o_row0       = row0_q;
    assign bus.o_row1       = row1_q;
    assign bus.o_load_en    = state_q == S_LOAD;
    assign bus.o_simd_start = state_q == S_START;
    assign bus.o_pix_valid  = pix_valid;
    assign bus.o_pix_data   = pix_q;
    assign bus.o_pix_mask   = pix_valid ? mask : '0;
    assign bus.o_pix_x      = gx;
    assign bus.o_pix_y      = gy;
    assign bus.o_busy       = state_q != S_IDLE && state_q != S_DONE;
    assign bus.o_done       = state_q == S_DONE;
    assign bus.o_err        = err_q;
endmodule

// File: tb/tb_simd_downscale_ctrl.sv
// tb_simd_downscale_ctrl: table-driven frames with a pixel-stream scoreboard,
// plus timeout, abort and mid-frame reset sequences.
module tb_simd_downscale_ctrl;
    import simd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simd_downscale_ctrl_if bus();
    simd_downscale_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int src_w, src_h, dst_w, dst_h, step_x, step_y;
        int fetch_lat, core_lat, hold;
        int exp_groups;
        logic [3:0] exp_last_mask;
        int exp_last_fx;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        int          x, y;
    } exp_t;

    vec_t tab[4];
    exp_t sb[$];
    int checks = 0, errors = 0, done_seen = 0, pix_cnt = 0;
    int last_fx, last_mask;

    always @(negedge clk) if (bus.o_done) done_seen++;
    always @(posedge clk) if (bus.o_pix_valid && bus.i_pix_ready) pix_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem(input int x, input int y);
        return 8'(10 * (x + 1) + 60 * y);
    endfunction

    function automatic logic [WIN*8-1:0] row(input int x0, input int y);
        logic [WIN*8-1:0] r;
        for (int i = 0; i < WIN; i++) r[8*i +: 8] = mem(x0 + i, y);
        return r;
    endfunction

    task automatic chk_zero(input string t);
        chk({t, "_busy"}, bus.o_busy, 0);
        chk({t, "_done"}, bus.o_done, 0);
        chk({t, "_err"}, bus.o_err, 0);
        chk({t, "_fetch_req"}, bus.o_fetch_req, 0);
        chk({t, "_fetch_x"}, bus.o_fetch_x, 0);
        chk({t, "_fetch_y1"}, bus.o_fetch_y1, 0);
        chk({t, "_load_en"}, bus.o_load_en, 0);
        chk({t, "_simd_start"}, bus.o_simd_start, 0);
        chk({t, "_row0"}, bus.o_row0, 0);
        chk({t, "_row1"}, bus.o_row1, 0);
        chk({t, "_wx"}, bus.o_wx, 0);
        chk({t, "_wy"}, bus.o_wy, 0);
        chk({t, "_pix_valid"}, bus.o_pix_valid, 0);
        chk({t, "_pix_data"}, bus.o_pix_data, 0);
        chk({t, "_pix_mask"}, bus.o_pix_mask, 0);
        chk({t, "_pix_x"}, bus.o_pix_x, 0);
        chk({t, "_pix_y"}, bus.o_pix_y, 0);
    endtask

    task automatic start_frame(input vec_t v);
        @(negedge clk);
        bus.i_src_w  = DIM_W'(v.src_w);
        bus.i_src_h  = DIM_W'(v.src_h);
        bus.i_dst_w  = DIM_W'(v.dst_w);
        bus.i_dst_h  = DIM_W'(v.dst_h);
        bus.i_step_x = 16'(v.step_x);
        bus.i_step_y = 16'(v.step_y);
        bus.i_start  = 1'b1;
        @(negedge clk);
        bus.i_start  = 1'b0;
        chk("busy_after_start", bus.o_busy, 1);
    endtask

    // fetch, load and start one group; returns at the negedge of the START cycle
    task automatic front(input vec_t v, input int r, input int g);
        int n, sx, sy, ix, iy, xm, fx, y0, y1;
        n = 0;
        while (!bus.o_fetch_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", bus.o_fetch_req, 1);
        sx = g * LANES * v.step_x;
        sy = r * v.step_y;
        ix = sx >> 8;
        iy = sy >> 8;
        xm = v.src_w > WIN ? v.src_w - WIN : 0;
        fx = ix > xm ? xm : ix;
        y0 = iy > v.src_h - 1 ? v.src_h - 1 : iy;
        y1 = y0 + 1 > v.src_h - 1 ? v.src_h - 1 : y0 + 1;
        chk("fetch_x", bus.o_fetch_x, fx);
        chk("fetch_y0", bus.o_fetch_y0, y0);
        chk("fetch_y1", bus.o_fetch_y1, y1);
        last_fx = int'(bus.o_fetch_x);
        for (int i = 0; i < v.fetch_lat; i++) begin
            @(negedge clk);
            chk("fetch_hold_req", bus.o_fetch_req, 1);
            chk("fetch_hold_x", bus.o_fetch_x, fx);
        end
        bus.i_fetch_row0 = row(fx, y0);
        bus.i_fetch_row1 = row(fx, y1);
        bus.i_fetch_ack  = 1'b1;
        @(negedge clk);
        bus.i_fetch_ack  = 1'b0;
        chk("load_en", bus.o_load_en, 1);
        chk("row0", bus.o_row0, row(fx, y0));
        chk("row1", bus.o_row1, row(fx, y1));
        @(negedge clk);
        chk("load_pulse", bus.o_load_en, 0);
        chk("simd_start", bus.o_simd_start, 1);
        chk("wx", bus.o_wx, sx & 255);
        chk("wy", bus.o_wy, sy & 255);
    endtask

    // core response and output handshake; returns at the negedge after the handshake edge
    task automatic back(input vec_t v, input int idx, input int r, input int g);
        logic [31:0] pv;
        logic [3:0]  m;
        exp_t        e;
        int          n, ng, rem;
        ng  = (v.dst_w + LANES - 1) / LANES;
        rem = v.dst_w % LANES;
        m   = (g == ng - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
        pv  = 32'hC0DE0000 | 32'(idx << 12) | 32'(r << 8) | 32'(g);
        for (int i = 0; i < v.core_lat; i++) @(negedge clk);
        bus.i_simd_valid = 1'b1;
        bus.i_pixel_vec  = pv;
        sb.push_back('{pv, m, g * LANES, r});
        @(negedge clk);
        bus.i_simd_valid = 1'b0;
        bus.i_pixel_vec  = '0;
        n = 0;
        while (!bus.o_pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pix_valid", bus.o_pix_valid, 1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.o_pix_valid, 1);
            chk("hold_data", bus.o_pix_data, pv);
            chk("hold_x", bus.o_pix_x, g * LANES);
            chk("hold_y", bus.o_pix_y, r);
            chk("hold_no_fetch", bus.o_fetch_req, 0);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at output actual=%0h", bus.o_pix_data);
        end else begin
            e = sb.pop_front();
            chk("pix_data", bus.o_pix_data, e.data);
            chk("pix_mask", bus.o_pix_mask, e.mask);
            chk("pix_x", bus.o_pix_x, e.x);
            chk("pix_y", bus.o_pix_y, e.y);
        end
        last_mask = int'(bus.o_pix_mask);
        bus.i_pix_ready = 1'b1;
        @(negedge clk);
        bus.i_pix_ready = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int p0, ng;
        p0 = pix_cnt;
        ng = (v.dst_w + LANES - 1) / LANES;
        start_frame(v);
        for (int r = 0; r < v.dst_h; r++)
            for (int g = 0; g < ng; g++) begin
                front(v, r, g);
                back(v, idx, r, g);
            end
        chk("done", bus.o_done, 1);
        chk("busy_at_done", bus.o_busy, 0);
        chk("groups", pix_cnt - p0, v.exp_groups);
        chk("last_mask", last_mask, v.exp_last_mask);
        chk("last_fetch_x", last_fx, v.exp_last_fx);
        @(negedge clk);
        chk("done_pulse", bus.o_done, 0);
    endtask

    initial begin
        int n, d0;
        bus.i_start = 0; bus.i_abort = 0; bus.i_fetch_ack = 0; bus.i_simd_valid = 0; bus.i_pix_ready = 0;
        bus.i_src_w = 0; bus.i_src_h = 0; bus.i_dst_w = 0; bus.i_dst_h = 0; bus.i_step_x = 0; bus.i_step_y = 0;
        bus.i_fetch_row0 = 0; bus.i_fetch_row1 = 0; bus.i_pixel_vec = 0;
        //          src_w src_h dst_w dst_h step_x  step_y  flat clat hold grp mask  lfx
        tab[0] = '{8,  2, 4, 1, 'h200, 'h200, 0, 0, 0, 1, 4'hF, 0};
        tab[1] = '{10, 4, 6, 2, 'h180, 'h200, 0, 2, 7, 4, 4'h3, 5};
        tab[2] = '{16, 8, 5, 3, 'h150, 'h270, 2, 1, 1, 6, 4'h1, 5};
        tab[3] = '{6,  3, 4, 4, 'h100, 'h100, 1, 3, 0, 4, 4'hF, 0};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_frame(tab[i], i);

        // core never answers
        d0 = done_seen;
        start_frame(tab[0]);
        front(tab[0], 0, 0);
        n = 0;
        while (!bus.o_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("err_cycles", n, WAIT_MAX + 1);
        chk("err_busy", bus.o_busy, 0);
        @(negedge clk);
        chk("err_pulse", bus.o_err, 0);
        chk("err_no_done", done_seen, d0);

        // abort wins over a simultaneous fetch ack
        d0 = done_seen;
        start_frame(tab[1]);
        bus.i_fetch_row0 = row(0, 0);
        bus.i_fetch_row1 = row(0, 1);
        bus.i_fetch_ack = 1'b1;
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_fetch_ack = 1'b0;
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_load", bus.o_load_en, 0);
        chk("abort_fetch", bus.o_fetch_req, 0);
        @(negedge clk);
        chk("abort_load_late", bus.o_load_en, 0);
        chk("abort_no_done", done_seen, d0);
        run_frame(tab[0], 4);

        // reset while the core is pending
        start_frame(tab[2]);
        front(tab[2], 0, 0);
        @(negedge clk);
        chk("pre_rst_busy", bus.o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        rst_n = 1'b1;
        run_frame(tab[2], 5);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
